// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK state (trailing
// modulo-256 checksum byte); without it the encoding has no CHK member.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/le_word_packer.sv
// Little-endian byte-to-word assembler. Holds bytes 0..2 of the current word;
// the word is presented combinationally together with the incoming byte 3 so
// the parent can register it on the same edge that accepts byte 3.
module le_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [1:0]      idx;
    logic [2:0][7:0] bytes_q;

    // Capture bytes 0..2 in place; index wraps 3->0 as a word completes.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            idx     <= 2'd0;
            bytes_q <= '0;
        end else if (accept) begin
            case (idx)
                2'd0:    bytes_q[0] <= in_data;
                2'd1:    bytes_q[1] <= in_data;
                2'd2:    bytes_q[2] <= in_data;
                default: ;
            endcase
            idx <= idx + 2'd1;
        end
    end

    // Byte 3 comes straight from the input; flag completion on that accept.
    always_comb begin
        word      = {in_data, bytes_q[2], bytes_q[1], bytes_q[0]};
        word_done = accept && (idx == 2'd3);
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream {N lo, N hi, 4*N data bytes},
// writes little-endian words to instruction memory, then releases the core.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a trailing byte must equal
// the modulo-256 sum of all data bytes or the load ends in ERR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_BYTES = 40,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic        LEN_LAST  = 1'(LEN_BYTES - 1);

    state_t            state;
    logic              len_idx;
    logic [7:0]        len_lo;
    logic [15:0]       len_n;
    logic [15:0]       word_cnt;
    logic [15:0]       hdr_n;
    logic [31:0]       hdr_bytes;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              xfer;
    logic              can_start;
    logic              pk_clr;
    logic              pk_accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    // Handshake and header decode helpers.
    always_comb begin
        xfer      = in_valid && in_ready;
        can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
        pk_clr    = start && can_start;
        pk_accept = xfer && (state == S_DATA);
        hdr_n     = {in_data, len_lo};
        hdr_bytes = {14'd0, hdr_n, 2'b00};
    end

    le_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pk_clr),
        .accept    (pk_accept),
        .in_data   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    // Load sequencer; every output is a register updated with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_idx    <= 1'b0;
            len_lo     <= '0;
            len_n      <= '0;
            word_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        in_ready   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        core_rst_n <= 1'b0;
                        len_idx    <= 1'b0;
                        len_lo     <= '0;
                        len_n      <= '0;
                        word_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        if (len_idx != LEN_LAST) begin
                            len_lo  <= in_data;
                            len_idx <= len_idx + 1'b1;
                        end else begin
                            len_n   <= hdr_n;
                            len_idx <= 1'b0;
                            if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state      <= S_CHK;
`else
                                state      <= S_DONE;
                                in_ready   <= 1'b0;
                                done       <= 1'b1;
                                core_rst_n <= 1'b1;
`endif
                            end else if (hdr_bytes > MEM_LIMIT) begin
                                state    <= S_ERR;
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + in_data;
`endif
                        if (word_done) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                            mem_wdata <= word;
                            word_cnt  <= word_cnt + 16'd1;
                            if (word_cnt == len_n - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state      <= S_CHK;
`else
                                state      <= S_DONE;
                                in_ready   <= 1'b0;
                                done       <= 1'b1;
                                core_rst_n <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == sum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// compared against a byte-stream reference model.
module tb_imem_loader;

    localparam int          MEM_BYTES = 40;
    localparam logic [31:0] BASE      = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, core_rst_n, done, err;
    logic [31:0] mem_waddr, mem_wdata;

    int          checks = 0;
    int          failures = 0;

    logic [63:0] wr_q[$];   // observed writes {addr, data}
    logic [63:0] exp_q[$];  // expected writes
    logic [7:0]  stim[$];   // full byte stream for one load
    bit          exp_done;
    int          n_send;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    // Record every write strobe cycle, away from the active edge.
    always @(negedge clk) if (mem_we) wr_q.push_back({mem_waddr, mem_wdata});

    // Reference model: what the byte stream should produce.
    function automatic void model_load();
        int n, s;
        logic [31:0] d;
        exp_q.delete();
        n = int'(stim[0]) + 256 * int'(stim[1]);
        if (4 * n > MEM_BYTES) begin
            exp_done = 1'b0;
            n_send   = 2;
            return;
        end
        s = 0;
        for (int w = 0; w < n; w++) begin
            d = 32'd0;
            for (int k = 0; k < 4; k++) begin
                d = d + 32'(stim[2 + 4*w + k]) * (32'd1 << (8*k));
                s = s + int'(stim[2 + 4*w + k]);
            end
            exp_q.push_back({BASE + 32'(4*w), d});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_done = (int'(stim[2 + 4*n]) == (s % 256));
        n_send   = 3 + 4*n;
`else
        exp_done = 1'b1;
        n_send   = 2 + 4*n;
`endif
    endfunction

    // Build a stream of n random words; bad_sum corrupts the checksum byte.
    task automatic gen_stim(input int n, input bit bad_sum);
        int s = 0;
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        for (int i = 0; i < 4*n; i++) begin
            stim.push_back(8'($urandom));
            s = s + int'(stim[stim.size()-1]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(bad_sum ? 8'(s + 1 + $urandom_range(0, 254)) : 8'(s));
`else
        if (bad_sum) s = 0;
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    // Offer one byte until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    // Start and feed stim[0 .. n_send-1] with random stalls of up to max_gap.
    task automatic run_load(input int max_gap);
        model_load();
        wr_q.delete();
        do_start();
        for (int i = 0; i < n_send; i++) begin
            idle_cycles($urandom_range(0, max_gap));
            send_byte(stim[i]);
        end
        idle_cycles(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        start = 1'b1;
        idle_cycles(3);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
        checks++; if (mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset mem regs: got %h/%h want 0/0", mem_waddr, mem_wdata); end
        checks++; if ({core_rst_n, done, err} !== 3'b000) begin failures++; $display("FAIL reset status: got %b want 000", {core_rst_n, done, err}); end
        start = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);
        checks++; if ({in_ready, core_rst_n, done} !== 3'b000) begin failures++; $display("FAIL idle after reset: got %b want 000", {in_ready, core_rst_n, done}); end
    endtask

    task automatic test_directed();
        stim = '{8'h02, 8'h00, 8'h83, 8'hA7, 8'h88, 8'h00, 8'h93, 8'h97, 8'h17, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(8'hF3);
`endif
        run_load(0);
        checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL directed write count: got %0d want 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0] !== {32'h0, 32'h0088A783}) begin failures++; $display("FAIL directed word0: got %h want 000000000088a783", wr_q[0]); end
            checks++; if (wr_q[1] !== {32'h4, 32'h00179793}) begin failures++; $display("FAIL directed word1: got %h want 0000000400179793", wr_q[1]); end
        end
        checks++; if ({done, err, core_rst_n, in_ready} !== 4'b1010) begin failures++; $display("FAIL directed status: got %b want 1010", {done, err, core_rst_n, in_ready}); end
        checks++; if (mem_waddr !== 32'h4 || mem_wdata !== 32'h00179793) begin failures++; $display("FAIL directed hold: got %h/%h want 4/00179793", mem_waddr, mem_wdata); end
    endtask

    task automatic test_too_long();
        stim = '{8'h0B, 8'h00};
        run_load(1);
        checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL too_long writes: got %0d want 0", wr_q.size()); end
        checks++; if ({err, done, core_rst_n, in_ready} !== 4'b1000) begin failures++; $display("FAIL too_long status: got %b want 1000", {err, done, core_rst_n, in_ready}); end
    endtask

    // Exactly MEM_BYTES of payload is allowed.
    task automatic test_capacity();
        gen_stim(MEM_BYTES / 4, 1'b0);
        run_load(0);
        checks++; if (wr_q.size() !== MEM_BYTES / 4) begin failures++; $display("FAIL capacity writes: got %0d want %0d", wr_q.size(), MEM_BYTES / 4); end
        checks++; if (wr_q.size() == exp_q.size() && wr_q[wr_q.size()-1] !== exp_q[exp_q.size()-1]) begin failures++; $display("FAIL capacity last word: got %h want %h", wr_q[wr_q.size()-1], exp_q[exp_q.size()-1]); end
        checks++; if ({done, err, core_rst_n} !== 3'b101) begin failures++; $display("FAIL capacity status: got %b want 101", {done, err, core_rst_n}); end
    endtask

    task automatic test_empty();
        stim = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(8'h00);
`endif
        run_load(1);
        checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL empty writes: got %0d want 0", wr_q.size()); end
        checks++; if ({done, err, core_rst_n} !== 3'b101) begin failures++; $display("FAIL empty status: got %b want 101", {done, err, core_rst_n}); end
    endtask

    // in_valid high every other cycle across one word.
    task automatic test_stall();
        gen_stim(1, 1'b0);
        model_load();
        wr_q.delete();
        do_start();
        for (int i = 0; i < n_send; i++) begin
            idle_cycles(1);
            send_byte(stim[i]);
        end
        idle_cycles(3);
        checks++; if (wr_q.size() !== 1) begin failures++; $display("FAIL stall writes: got %0d want 1", wr_q.size()); end
        checks++; if (wr_q.size() == 1 && wr_q[0] !== exp_q[0]) begin failures++; $display("FAIL stall word: got %h want %h", wr_q[0], exp_q[0]); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall done: got %b want 1", done); end
    endtask

    // start pulses mid-load must not restart it.
    task automatic test_ignore_start();
        gen_stim(2, 1'b0);
        model_load();
        wr_q.delete();
        do_start();
        for (int i = 0; i < n_send; i++) begin
            if (i == 1 || i == 5) do_start();
            send_byte(stim[i]);
        end
        idle_cycles(3);
        checks++; if (wr_q.size() !== exp_q.size()) begin failures++; $display("FAIL ignore_start writes: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL ignore_start word%0d: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_start done: got %b want 1", done); end
    endtask

    // Restart from DONE and from ERR.
    task automatic test_back_to_back();
        stim = '{8'h0C, 8'h00};
        run_load(0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL b2b err set: got %b want 1", err); end
        do_start();
        checks++; if ({err, done, core_rst_n, in_ready} !== 4'b0001) begin failures++; $display("FAIL b2b restart from err: got %b want 0001", {err, done, core_rst_n, in_ready}); end
        idle_cycles(2);
        gen_stim(1, 1'b0);
        run_load(0);
        checks++; if (done !== 1'b1 || wr_q.size() !== 1) begin failures++; $display("FAIL b2b load: got done=%b writes=%0d want 1/1", done, wr_q.size()); end
        do_start();
        checks++; if ({err, done, core_rst_n, in_ready} !== 4'b0001) begin failures++; $display("FAIL b2b restart from done: got %b want 0001", {err, done, core_rst_n, in_ready}); end
        rst_n = 1'b0;
        idle_cycles(1);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            gen_stim($urandom_range(0, 12), ($urandom_range(0, 3) == 0));
            run_load(2);
            checks++; if (wr_q.size() !== exp_q.size()) begin failures++; $display("FAIL random%0d writes: got %0d want %0d", it, wr_q.size(), exp_q.size()); end
            for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
                checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL random%0d word%0d: got %h want %h", it, i, wr_q[i], exp_q[i]); end
            end
            checks++; if ({done, err, core_rst_n} !== {exp_done, !exp_done, exp_done}) begin failures++; $display("FAIL random%0d status: got %b want %b", it, {done, err, core_rst_n}, {exp_done, !exp_done, exp_done}); end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        run_load(0);
        checks++; if ({err, done, core_rst_n} !== 3'b100) begin failures++; $display("FAIL checksum bad: got %b want 100", {err, done, core_rst_n}); end
        stim[6] = 8'h13;
        run_load(0);
        checks++; if ({err, done, core_rst_n} !== 3'b011) begin failures++; $display("FAIL checksum good: got %b want 011", {err, done, core_rst_n}); end
    endtask
`endif

    // Reset after three bytes of a word: no write, loader idle.
    task automatic test_reset_mid();
        gen_stim(1, 1'b0);
        wr_q.delete();
        do_start();
        for (int i = 0; i < 5; i++) send_byte(stim[i]);
        in_valid = 1'b1;
        in_data  = stim[5];
        rst_n    = 1'b0;
        idle_cycles(1);
        rst_n = 1'b1;
        idle_cycles(4);
        in_valid = 1'b0;
        idle_cycles(1);
        checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL reset_mid writes: got %0d want 0", wr_q.size()); end
        checks++; if ({in_ready, done, err, core_rst_n} !== 4'b0000) begin failures++; $display("FAIL reset_mid status: got %b want 0000", {in_ready, done, err, core_rst_n}); end
        checks++; if (mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mid mem regs: got %h/%h want 0/0", mem_waddr, mem_wdata); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_too_long();
        test_capacity();
        test_empty();
        test_stall();
        test_ignore_start();
        test_back_to_back();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
